// File: rtl/pwm_output_stage.sv
// pwm_output_stage
//   Generates one shared 8-bit PWM waveform and gates it onto 16 output pins
//   according to the output-enable and PWM-select registers from the SPI
//   register block.
//
//   Optional feature macro: PWM_DUTY_SHADOW_EN
//     defined   : duty value is latched once per period, on the wrap cycle
//     undefined : duty value is used combinationally (takes effect next clock)
//
// Parameters
//   CLK_DIV          system clocks per PWM counter step (1..255)
// Ports
//   clk              system clock, rising edge
//   rst              synchronous active-high reset
//   en_reg_out_7_0   output enable, pins 7..0
//   en_reg_out_15_8  output enable, pins 15..8
//   en_reg_pwm_7_0   PWM select, pins 7..0
//   en_reg_pwm_15_8  PWM select, pins 15..8
//   pwm_duty_cycle   duty value in 1/256 steps (0xFF = 100%)
//   out              registered pin drive
//   period_start     high in the first clock of each PWM period
module pwm_output_stage #(
  parameter int unsigned CLK_DIV = 13
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [7:0]  en_reg_out_7_0,
  input  logic [7:0]  en_reg_out_15_8,
  input  logic [7:0]  en_reg_pwm_7_0,
  input  logic [7:0]  en_reg_pwm_15_8,
  input  logic [7:0]  pwm_duty_cycle,
  output logic [15:0] out,
  output logic        period_start
);

  localparam int unsigned PW = (CLK_DIV <= 1) ? 1 : $clog2(CLK_DIV);
  localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_DIV - 1);

  logic [15:0]   en_out, en_pwm;
  logic [PW-1:0] presc_q, presc_d;
  logic [7:0]    cnt_q, cnt_d;
  logic [15:0]   out_q, out_d;
  logic [7:0]    duty_act;
  logic          presc_last, wrap, pwm_sig;

  assign en_out = {en_reg_out_15_8, en_reg_out_7_0};
  assign en_pwm = {en_reg_pwm_15_8, en_reg_pwm_7_0};

  assign presc_last = (presc_q == PRESC_LAST);
  // Last clock of the period: the next edge returns both counters to zero.
  assign wrap       = presc_last && (cnt_q == 8'hFF);

`ifdef PWM_DUTY_SHADOW_EN
  logic [7:0] duty_q, duty_d;

  // Load only at the wrap so every period sees exactly one duty value.
  always_comb begin
    duty_d = duty_q;
    if (wrap) duty_d = pwm_duty_cycle;
  end

  always_ff @(posedge clk) begin
    if (rst) duty_q <= 8'h00;
    else     duty_q <= duty_d;
  end

  assign duty_act = duty_q;
`else
  assign duty_act = pwm_duty_cycle;
`endif

  // 0xFF is forced high so full scale means no low cycle at all.
  assign pwm_sig = (duty_act == 8'hFF) || (cnt_q < duty_act);

  always_comb begin
    presc_d = presc_last ? '0 : presc_q + PW'(1);
    cnt_d   = presc_last ? cnt_q + 8'd1 : cnt_q;
    // Disabled pins drive 0; enabled pins drive PWM if selected, else 1.
    out_d   = en_out & (~en_pwm | {16{pwm_sig}});
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      presc_q <= '0;
      cnt_q   <= 8'h00;
      out_q   <= 16'h0000;
    end else begin
      presc_q <= presc_d;
      cnt_q   <= cnt_d;
      out_q   <= out_d;
    end
  end

  assign out          = out_q;
  // State-only decode; no combinational path from any input.
  assign period_start = (presc_q == '0) && (cnt_q == 8'h00);

endmodule
